// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Purpose  : Power-up, lock-acquisition and recovery sequencer for a PLLE2.
//            Holds the PLL in reset, waits for LOCKED, qualifies it for a
//            stability window and only then releases the downstream system
//            reset. Lock timeouts and glitches are retried up to MAX_RETRIES
//            times before a sticky FAULT. Loss of lock in RUN restarts the
//            whole sequence. Runs on the free-running reference clock.
// Ports    : clk_i        reference clock (same net as PLL CLKIN1)
//            rst_i        synchronous active-high reset
//            restart_i    single-cycle restart request, clears retry count
//            pll_locked_i PLL LOCKED, asynchronous to clk_i
//            pll_rst_o    PLL RST (1 = PLL held in reset)
//            sys_rst_o    active-high reset for PLL-clocked logic
//            ready_o      clocks locked and stable (complement of sys_rst_o)
//            fault_o      retry budget exhausted
//            lock_lost_o  one-cycle pulse on lock loss during RUN
//            retries_o    failed attempts since last RUN entry or restart
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 20,
  parameter int RETRY_W       = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               restart_i,
  input  logic               pll_locked_i,
  output logic               pll_rst_o,
  output logic               sys_rst_o,
  output logic               ready_o,
  output logic               fault_o,
  output logic               lock_lost_o,
  output logic [RETRY_W-1:0] retries_o
);

  localparam logic [CNT_W-1:0]   c_reset_last   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   c_stable_last  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] c_max_retries  = RETRY_W'(MAX_RETRIES);
  localparam logic [CNT_W-1:0]   c_cnt_one      = CNT_W'(1);
  localparam logic [RETRY_W-1:0] c_retry_one    = RETRY_W'(1);

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  // Two-flop synchroniser for the asynchronous LOCKED input
  logic               sync1_q;
  logic               lock_s_q;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic               lock_lost_q, lock_lost_d;
  logic               attempt_fail;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      retries_q   <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      sync1_q     <= pll_locked_i;
      lock_s_q    <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retries_d    = retries_q;
    lock_lost_d  = 1'b0;
    attempt_fail = 1'b0;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == c_reset_last) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      ST_WAIT: begin
        if (lock_s_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == c_timeout_last) begin
          attempt_fail = 1'b1;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      ST_STABLE: begin
        if (!lock_s_q) begin
          attempt_fail = 1'b1;
        end else if (cnt_q == c_stable_last) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          retries_d = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          state_d     = ST_HOLD;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end
      end
      ST_FAULT: begin
        // Sticky until rst_i or restart_i
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase

    // A failed attempt either retries or, once the budget is spent, faults.
    // retries never increments past c_max_retries, so it cannot wrap.
    if (attempt_fail) begin
      cnt_d = '0;
      if (retries_q == c_max_retries) begin
        state_d = ST_FAULT;
      end else begin
        state_d   = ST_HOLD;
        retries_d = retries_q + c_retry_one;
      end
    end

    // Restart overrides everything, including a coincident lock-loss pulse
    if (restart_i) begin
      state_d     = ST_HOLD;
      cnt_d       = '0;
      retries_d   = '0;
      lock_lost_d = 1'b0;
    end

    // Outputs are decoded from the next state so they switch on the entry edge
    pll_rst_d = (state_d == ST_HOLD) || (state_d == ST_FAULT);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  assign pll_rst_o   = pll_rst_q;
  assign sys_rst_o   = sys_rst_q;
  assign ready_o     = ready_q;
  assign fault_o     = fault_q;
  assign lock_lost_o = lock_lost_q;
  assign retries_o   = retries_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Purpose  : Directed self-checking bench for pll_reset_sequencer with
//            RESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
//            Inputs change 1 time unit after a rising edge; outputs are
//            sampled at the same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       restart;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [1:0] retries;

  int n_cmp;
  int n_err;
  int n;

  pll_reset_sequencer #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2),
    .CNT_W        (20),
    .RETRY_W      (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .restart_i   (restart),
    .pll_locked_i(locked),
    .pll_rst_o   (pll_rst),
    .sys_rst_o   (sys_rst),
    .ready_o     (ready),
    .fault_o     (fault),
    .lock_lost_o (lock_lost),
    .retries_o   (retries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // sel: 0 = pll_rst, 1 = ready, 2 = lock_lost. Counts edges until the
  // selected output equals val; stops at budget so the bench never hangs.
  function automatic logic pick(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return ready;
      default: return lock_lost;
    endcase
  endfunction

  task automatic count_until(input int sel, input logic val, input int budget,
                             output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while ((pick(sel) !== val) && (cnt < budget));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    restart = 1'b0;
    locked  = 1'b0;
    ticks(3);

    // Reset state
    chk("rst_pll_rst",   pll_rst,   1);
    chk("rst_sys_rst",   sys_rst,   1);
    chk("rst_ready",     ready,     0);
    chk("rst_fault",     fault,     0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_retries",   retries,   0);

    // 1: normal lock. PLL RST held 4 cycles after reset release.
    rst = 1'b0;
    count_until(0, 1'b0, 20, n);
    chk("t1_hold_len", n, 4);
    chk("t1_sys_rst_wait", sys_rst, 1);
    ticks(9);
    locked = 1'b1;
    tick();                         // first edge that samples LOCKED high
    count_until(1, 1'b1, 40, n);
    chk("t1_lock_to_ready", n, 10);
    chk("t1_sys_rst_run", sys_rst, 0);
    chk("t1_pll_rst_run", pll_rst, 0);
    chk("t1_retries_run", retries, 0);

    // 4: loss of lock in RUN, then (2) no lock -> full retry budget -> FAULT
    locked = 1'b0;
    tick();
    count_until(2, 1'b1, 10, n);
    chk("t4_lost_delay", n, 2);
    chk("t4_sys_rst",  sys_rst, 1);
    chk("t4_ready",    ready,   0);
    chk("t4_pll_rst",  pll_rst, 1);
    chk("t4_retries",  retries, 0);
    tick();
    chk("t4_pulse_width", lock_lost, 0);
    chk("t4_pll_rst_2",   pll_rst,   1);
    count_until(0, 1'b0, 20, n);
    chk("t4_hold_rest", n, 3);

    for (int a = 0; a < 3; a++) begin
      ticks(31);
      chk("t2_wait_retries", retries, a);
      chk("t2_wait_pll_rst", pll_rst, 0);
      tick();
      if (a < 2) begin
        chk("t2_fail_retries", retries, a + 1);
        chk("t2_fail_pll_rst", pll_rst, 1);
        chk("t2_fail_fault",   fault,   0);
        ticks(4);
        chk("t2_hold_done", pll_rst, 0);
      end else begin
        chk("t2_fault",         fault,   1);
        chk("t2_fault_pll_rst", pll_rst, 1);
        chk("t2_fault_sys_rst", sys_rst, 1);
        chk("t2_fault_retries", retries, 2);
      end
    end
    ticks(50);
    chk("t2_fault_sticky",  fault,   1);
    chk("t2_sticky_pll",    pll_rst, 1);
    chk("t2_sticky_ready",  ready,   0);

    // 5: restart from FAULT
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t5_fault_clr",   fault,   0);
    chk("t5_retries_clr", retries, 0);
    chk("t5_pll_rst",     pll_rst, 1);
    count_until(0, 1'b0, 20, n);
    chk("t5_hold_len", n, 4);

    // 3: glitch during STABLE. STABLE entered 3 edges after LOCKED set.
    locked = 1'b1;
    ticks(3);
    ticks(4);
    locked = 1'b0;
    ticks(3);
    chk("t3_retries", retries, 1);
    chk("t3_pll_rst", pll_rst, 1);
    chk("t3_ready",   ready,   0);
    locked = 1'b1;
    // HOLD 4 -> WAIT (lock already synced) -> STABLE 1 -> RUN 8 = 13
    count_until(1, 1'b1, 40, n);
    chk("t3_to_run",      n,       13);
    chk("t3_run_retries", retries, 0);

    // 5b: restart coincident with lock loss in RUN: no pulse
    locked = 1'b0;
    ticks(2);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t5b_no_pulse", lock_lost, 0);
    chk("t5b_pll_rst",  pll_rst,   1);
    chk("t5b_ready",    ready,     0);
    tick();
    chk("t5b_no_pulse2", lock_lost, 0);

    // 6: reset mid-WAIT (second attempt so retries is non-zero)
    count_until(0, 1'b0, 20, n);     // WAIT of attempt 1
    ticks(32 + 4);                   // timeout, HOLD, into WAIT of attempt 2
    chk("t6_pre_retries", retries, 1);
    chk("t6_pre_pll_rst", pll_rst, 0);
    ticks(20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_pll_rst", pll_rst, 1);
    chk("t6_sys_rst", sys_rst, 1);
    chk("t6_retries", retries, 0);
    chk("t6_ready",   ready,   0);
    chk("t6_fault",   fault,   0);
    count_until(0, 1'b0, 20, n);
    chk("t6_hold_len", n, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
